// File: rtl/case2_frame_loader.sv
// case2_frame_loader
// Byte-serial feeder for the case-2 alpha/beta core. One input frame per decode:
// I H rows (BPR bytes each, LSB byte first), then A alpha columns (J bytes
// each). Emits I H_row beats of J bits, then A alpha_u_col beats of J*8 bits.
// It also checks the frame length against s_tlast and counts good frames.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   s_tdata/s_tvalid/
//   s_tlast/s_tready     : byte input stream
//   hold                 : downstream back-pressure (takes effect one cycle late)
//   H_row*               : H row beat + valid/last pulses
//   alpha_u_col*         : alpha column beat (element j at [j*8 +: 8]) + pulses
//   frame_err            : one-cycle pulse on a length mismatch
//   frame_cnt            : good frames since reset (wraps)
//   dbg_state            : current FSM state (H_LOAD=0, A_LOAD=1, DRAIN=2)
//
// Handshake: a byte transfers on a rising edge where s_tvalid & s_tready are
// both 1. The source must hold s_tdata/s_tlast stable while s_tvalid is high
// and s_tready is low. Output beats have no ready; they are single-cycle pulses.
module case2_frame_loader #(
  parameter int J        = 14,
  parameter int I        = 7,
  parameter int A        = 2,
  parameter int ZERO_FIX = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  input  logic             hold,
  output logic [J-1:0]     H_row,
  output logic             H_row_tvalid,
  output logic             H_row_tlast,
  output logic [J*8-1:0]   alpha_u_col,
  output logic             alpha_u_col_tvalid,
  output logic             alpha_u_col_tlast,
  output logic             frame_err,
  output logic [15:0]      frame_cnt,
  output logic [1:0]       dbg_state
);

  localparam int BPR = (J + 7) / 8;
  // The byte counter indexes both row bytes (< BPR) and column elements (< J).
  localparam int BW  = $clog2(J + 1);
  localparam int RW  = $clog2(I + 1);
  localparam int CW  = $clog2(A + 1);

  typedef enum logic [1:0] {
    H_LOAD = 2'd0,
    A_LOAD = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t         r_state, w_state_nx;
  logic [BW-1:0]  r_byte, w_byte_nx;
  logic [RW-1:0]  r_row, w_row_nx;
  logic [CW-1:0]  r_col, w_col_nx;
  logic [J-1:0]   r_h_asm, w_h_asm_nx;
  logic [J*8-1:0] r_a_asm, w_a_asm_nx;
  logic [J-1:0]   r_h_row, w_h_row_nx;
  logic           r_h_vld, w_h_vld_nx, r_h_last, w_h_last_nx;
  logic [J*8-1:0] r_a_col, w_a_col_nx;
  logic           r_a_vld, w_a_vld_nx, r_a_last, w_a_last_nx;
  logic           r_err, w_err_nx;
  logic [15:0]    r_cnt, w_cnt_nx;
  logic           r_tready;
  logic           w_acc;
  logic [7:0]     w_abyte;

  assign w_acc   = s_tvalid & r_tready;
  // A zero alpha would later be used as a divisor; replace it with 1.
  assign w_abyte = ((ZERO_FIX != 0) && (s_tdata == 8'd0)) ? 8'd1 : s_tdata;

  always_comb begin
    w_state_nx  = r_state;
    w_byte_nx   = r_byte;
    w_row_nx    = r_row;
    w_col_nx    = r_col;
    w_h_asm_nx  = r_h_asm;
    w_a_asm_nx  = r_a_asm;
    w_h_row_nx  = r_h_row;
    w_h_vld_nx  = 1'b0;
    w_h_last_nx = 1'b0;
    w_a_col_nx  = r_a_col;
    w_a_vld_nx  = 1'b0;
    w_a_last_nx = 1'b0;
    w_err_nx    = 1'b0;
    w_cnt_nx    = r_cnt;
    if (w_acc) begin
      case (r_state)
        H_LOAD: begin
          // Only bits below J are kept; the excess of the last row byte drops.
          for (int i = 0; i < J; i++) begin
            if ((i / 8) == int'(r_byte)) w_h_asm_nx[i] = s_tdata[i % 8];
          end
          if (s_tlast) begin
            // Any tlast during the H section is early.
            w_err_nx   = 1'b1;
            w_byte_nx  = '0;
            w_row_nx   = '0;
            w_col_nx   = '0;
            w_state_nx = H_LOAD;
          end else if (r_byte == BW'(BPR - 1)) begin
            w_h_row_nx  = w_h_asm_nx;
            w_h_vld_nx  = 1'b1;
            w_h_last_nx = (r_row == RW'(I - 1));
            w_byte_nx   = '0;
            if (r_row == RW'(I - 1)) begin
              w_row_nx   = '0;
              w_state_nx = A_LOAD;
            end else begin
              w_row_nx = r_row + 1'b1;
            end
          end else begin
            w_byte_nx = r_byte + 1'b1;
          end
        end
        A_LOAD: begin
          w_a_asm_nx[int'(r_byte)*8 +: 8] = w_abyte;
          if ((r_byte == BW'(J - 1)) && (r_col == CW'(A - 1))) begin
            // Final column is emitted whether or not tlast is on time.
            w_a_col_nx  = w_a_asm_nx;
            w_a_vld_nx  = 1'b1;
            w_a_last_nx = 1'b1;
            w_byte_nx   = '0;
            w_col_nx    = '0;
            if (s_tlast) begin
              w_cnt_nx   = r_cnt + 16'd1;
              w_state_nx = H_LOAD;
            end else begin
              w_err_nx   = 1'b1;
              w_state_nx = DRAIN;
            end
          end else if (s_tlast) begin
            // Early tlast: the partial (or just-completed) beat is dropped.
            w_err_nx   = 1'b1;
            w_byte_nx  = '0;
            w_row_nx   = '0;
            w_col_nx   = '0;
            w_state_nx = H_LOAD;
          end else if (r_byte == BW'(J - 1)) begin
            w_a_col_nx = w_a_asm_nx;
            w_a_vld_nx = 1'b1;
            w_byte_nx  = '0;
            w_col_nx   = r_col + 1'b1;
          end else begin
            w_byte_nx = r_byte + 1'b1;
          end
        end
        DRAIN: begin
          if (s_tlast) w_state_nx = H_LOAD;
        end
        default: w_state_nx = H_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= H_LOAD;
      r_byte   <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_h_asm  <= '0;
      r_a_asm  <= '0;
      r_h_row  <= '0;
      r_h_vld  <= 1'b0;
      r_h_last <= 1'b0;
      r_a_col  <= '0;
      r_a_vld  <= 1'b0;
      r_a_last <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_tready <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_byte   <= w_byte_nx;
      r_row    <= w_row_nx;
      r_col    <= w_col_nx;
      r_h_asm  <= w_h_asm_nx;
      r_a_asm  <= w_a_asm_nx;
      r_h_row  <= w_h_row_nx;
      r_h_vld  <= w_h_vld_nx;
      r_h_last <= w_h_last_nx;
      r_a_col  <= w_a_col_nx;
      r_a_vld  <= w_a_vld_nx;
      r_a_last <= w_a_last_nx;
      r_err    <= w_err_nx;
      r_cnt    <= w_cnt_nx;
      // Registered, so hold is seen one cycle late.
      r_tready <= !hold;
    end
  end

  assign s_tready           = r_tready;
  assign H_row              = r_h_row;
  assign H_row_tvalid       = r_h_vld;
  assign H_row_tlast        = r_h_last;
  assign alpha_u_col        = r_a_col;
  assign alpha_u_col_tvalid = r_a_vld;
  assign alpha_u_col_tlast  = r_a_last;
  assign frame_err          = r_err;
  assign frame_cnt          = r_cnt;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_case2_frame_loader.sv
module tb_case2_frame_loader;
  localparam int J  = 14;
  localparam int I  = 7;
  localparam int A  = 2;
  localparam int NB = 42;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] s_tdata = 8'd0;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       hold = 1'b0;

  logic           s_tready, h_vld, h_last, a_vld, a_last, f_err;
  logic [J-1:0]   h_row;
  logic [J*8-1:0] a_col;
  logic [15:0]    f_cnt;
  logic [1:0]     dbg;

  logic           s_tready0, h_vld0, h_last0, a_vld0, a_last0, f_err0;
  logic [J-1:0]   h_row0;
  logic [J*8-1:0] a_col0;
  logic [15:0]    f_cnt0;
  logic [1:0]     dbg0;

  case2_frame_loader #(.J(J), .I(I), .A(A), .ZERO_FIX(1)) dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .hold(hold), .H_row(h_row), .H_row_tvalid(h_vld),
    .H_row_tlast(h_last), .alpha_u_col(a_col), .alpha_u_col_tvalid(a_vld),
    .alpha_u_col_tlast(a_last), .frame_err(f_err), .frame_cnt(f_cnt), .dbg_state(dbg)
  );

  case2_frame_loader #(.J(J), .I(I), .A(A), .ZERO_FIX(0)) dut0 (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready0), .hold(hold), .H_row(h_row0), .H_row_tvalid(h_vld0),
    .H_row_tlast(h_last0), .alpha_u_col(a_col0), .alpha_u_col_tvalid(a_vld0),
    .alpha_u_col_tlast(a_last0), .frame_err(f_err0), .frame_cnt(f_cnt0), .dbg_state(dbg0)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;
  logic [J:0]   exp_h_q[$];
  logic [J*8:0] exp_a_q[$];
  logic [J*8:0] exp_a0_q[$];
  logic [J:0]   eh;
  logic [J*8:0] ea, ea0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (h_vld || a_vld) chk("h_a_overlap", h_vld & a_vld, 1'b0);
    if (h_vld) begin
      if (exp_h_q.size() == 0) chk("h_unexpected", 1'b1, 1'b0);
      else begin
        eh = exp_h_q.pop_front();
        chk("h_row", h_row, eh[J-1:0]);
        chk("h_last", h_last, eh[J]);
      end
    end else if (h_last) chk("h_last_no_vld", h_last, 1'b0);
    if (a_vld) begin
      if (exp_a_q.size() == 0) chk("a_unexpected", 1'b1, 1'b0);
      else begin
        ea = exp_a_q.pop_front();
        chk("a_col", a_col, ea[J*8-1:0]);
        chk("a_last", a_last, ea[J*8]);
      end
    end else if (a_last) chk("a_last_no_vld", a_last, 1'b0);
    if (a_vld0) begin
      if (exp_a0_q.size() == 0) chk("a0_unexpected", 1'b1, 1'b0);
      else begin
        ea0 = exp_a0_q.pop_front();
        chk("a0_col", a_col0, ea0[J*8-1:0]);
        chk("a0_last", a_last0, ea0[J*8]);
      end
    end
  end

  // s_tready must equal !hold as seen at the previous edge (0 under reset).
  logic h_s, r_s;
  always begin
    @(posedge clk);
    h_s = hold;
    r_s = rst;
    #1;
    chk("tready_lag", s_tready, r_s ? 1'b0 : !h_s);
  end

  // random hold when enabled
  logic hold_en = 1'b0;
  always @(negedge clk) hold = hold_en ? ($urandom_range(0, 3) == 0) : 1'b0;

  // ---------------- frame data ----------------
  logic [7:0]   cur_hb[14];
  logic [J-1:0] cur_hx[7];
  logic [7:0]   cur_ab[28];

  task automatic load_nominal();
    cur_hb = '{8'hFF, 8'h3F, 8'h01, 8'h00, 8'hAA, 8'h2A, 8'h55, 8'h15,
               8'h0F, 8'h0F, 8'h00, 8'h30, 8'hFF, 8'h00};
    cur_hx = '{14'h3FFF, 14'h0001, 14'h2AAA, 14'h1555, 14'h0F0F, 14'h3000, 14'h00FF};
    for (int k = 0; k < 28; k++) cur_ab[k] = 8'(k + 1);
  endtask

  task automatic push_expect(input int n_h, input int n_a);
    logic [J*8-1:0] col, col0;
    logic [7:0] b;
    for (int r = 0; r < n_h; r++) exp_h_q.push_back({(r == I - 1), cur_hx[r]});
    for (int c = 0; c < n_a; c++) begin
      for (int j = 0; j < J; j++) begin
        b = cur_ab[c*J + j];
        col0[j*8 +: 8] = b;
        col[j*8 +: 8]  = (b == 8'd0) ? 8'd1 : b;
      end
      exp_a_q.push_back({(c == A - 1), col});
      exp_a0_q.push_back({(c == A - 1), col0});
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int t = 0;
    s_tdata = d;
    s_tvalid = 1'b1;
    s_tlast = l;
    while (s_tready !== 1'b1 && t <= 200) begin
      @(negedge clk);
      t++;
    end
    if (t > 200) chk("ready_timeout", 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic send_frame(input int nbytes, input int tlast_at, input bit gaps);
    logic [7:0] d;
    bit early, e_h, e_a, e_e;
    for (int b = 0; b < nbytes; b++) begin
      if (gaps) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      d = (b < 14) ? cur_hb[b] : (b < NB) ? cur_ab[b-14] : 8'hEE;
      send_byte(d, (b == tlast_at));
      early = (b == tlast_at) && (b < NB - 1);
      e_h = !early && (b < 14) && (b % 2 == 1);
      e_a = !early && (b >= 14) && (b < NB) && ((b - 14) % J == J - 1);
      e_e = early || ((b == NB - 1) && (tlast_at != NB - 1));
      chk("h_vld_lat", h_vld, e_h);
      chk("a_vld_lat", a_vld, e_a);
      chk("err_lat", f_err, e_e);
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_tready", s_tready, 1'b0);
    chk("rst_h_row", h_row, '0);
    chk("rst_h_vld", h_vld, 1'b0);
    chk("rst_h_last", h_last, 1'b0);
    chk("rst_a_col", a_col, '0);
    chk("rst_a_vld", a_vld, 1'b0);
    chk("rst_a_last", a_last, 1'b0);
    chk("rst_err", f_err, 1'b0);
    chk("rst_cnt", f_cnt, 16'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);

    // nominal 42-byte frame
    load_nominal();
    push_expect(7, 2);
    send_frame(NB, NB - 1, 0);
    chk("cnt_nominal", f_cnt, 16'd1);

    // row byte 1 = 0xFF (upper bits dropped), zero alpha bytes
    cur_hb[0] = 8'h34; cur_hb[1] = 8'hFF; cur_hx[0] = 14'h3F34;
    cur_hb[2] = 8'hC3; cur_hb[3] = 8'hC0; cur_hx[1] = 14'h00C3;
    cur_ab[3] = 8'h00; cur_ab[20] = 8'h00;
    push_expect(7, 2);
    send_frame(NB, NB - 1, 0);
    chk("cnt_zero", f_cnt, 16'd2);

    // early tlast on byte 20
    load_nominal();
    push_expect(7, 0);
    send_frame(21, 20, 0);
    chk("cnt_early", f_cnt, 16'd2);
    push_expect(7, 2);
    send_frame(NB, NB - 1, 0);
    chk("cnt_after_early", f_cnt, 16'd3);

    // 45-byte frame, tlast on byte 44
    push_expect(7, 2);
    send_frame(45, 44, 0);
    chk("cnt_long", f_cnt, 16'd3);
    push_expect(7, 2);
    send_frame(NB, NB - 1, 0);
    chk("cnt_after_long", f_cnt, 16'd4);

    // gapped / held run, reset in the middle of frame 2
    hold_en = 1'b1;
    push_expect(7, 2);
    send_frame(NB, NB - 1, 1);
    chk("cnt_gap1", f_cnt, 16'd5);
    push_expect(5, 0);
    send_frame(10, -1, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);
    push_expect(7, 2);
    send_frame(NB, NB - 1, 1);
    chk("cnt_gap3", f_cnt, 16'd1);
    hold_en = 1'b0;

    repeat (4) @(negedge clk);
    chk("h_q_empty", exp_h_q.size(), 0);
    chk("a_q_empty", exp_a_q.size(), 0);
    chk("a0_q_empty", exp_a0_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
